gcm_len_tracker: RTL and testbench
==================================

// Module: gcm_len_tracker
// PURPOSE
//  Byte-granular GCM length tracker for the GHASH datapath. Counts AAD and text
//  bit lengths per message, with partial final blocks and AAD-before-text
//  sequencing. On finish, presents the len(A)||len(C) block through a
//  valid/ready handshake, then rearms for the next message.
// PARAMETERS
//  LEN_W       64           width of each bit-length field, 8..64
//  A_MAX_BITS  64'hFFFF_FFFF_FFFF_FFFF  AAD bit limit (GCM_LEN_LIMIT_EN only)
//  C_MAX_BITS  (2**39)-256  text bit limit (GCM_LEN_LIMIT_EN only)
// PORTS
//  clk        in   1        clock
//  rst_n      in   1        async active-low reset
//  clr_i      in   1        sync clear: abort message, zero all state and flags
//  aad_vld_i  in   1        AAD beat of nbytes_i bytes
//  txt_vld_i  in   1        text beat of nbytes_i bytes
//  nbytes_i   in   5        bytes in beat, 1..16; 0 = beat ignored
//  fin_i      in   1        end of message
//  len_vld_o  out  1        len block valid
//  len_rdy_i  in   1        consumer accepts len block
//  len_blk_o  out  2*LEN_W  {len_a, len_c} in bits
//  busy_o     out  1        state != IDLE
//  seq_err_o  out  1        sticky sequencing error
//  lim_err_o  out  1        sticky length-limit error
// BEHAVIOUR
//  - Reset (rst_n=0, async) and clr_i (sync, top priority): state IDLE,
//    len_a=len_c=0, all outputs 0.
//  - States: IDLE, AAD, TXT, OUT. len_vld_o=1 iff OUT. busy_o=1 iff not IDLE.
//  - Accepted beat adds {nbytes_i,3'b000} to len_a (AAD) or len_c (text),
//    zero-extended to LEN_W. The result is visible on the next cycle.
//  - IDLE/AAD + AAD beat -> AAD. IDLE/AAD/TXT + text beat -> TXT.
//  - fin_i in IDLE/AAD/TXT -> OUT. A beat in the same cycle as fin_i is counted
//    first. fin_i with no beats gives a len block of 0.
//  - OUT: len_blk_o is held stable. len_rdy_i=1 -> IDLE with counters zeroed in
//    the same edge. Back-to-back messages are possible one cycle later.
//  - A phase ends after a partial beat (nbytes_i<16). Any further beat of that
//    phase is ignored and sets seq_err_o.
//  - Also ignored with seq_err_o set:
//    - AAD beat in TXT;
//    - any beat or fin_i in OUT;
//    - aad_vld_i and txt_vld_i in the same cycle (both dropped; fin_i still acts);
//    - nbytes_i>16.
//  - Error flags are sticky until clr_i or reset. They do not block counting.
// CONFIGURATION
//  GCM_LEN_LIMIT_EN defined:
//    - A beat whose sum would exceed A_MAX_BITS / C_MAX_BITS is not counted.
//    - lim_err_o is set. The state still advances as for an accepted beat.
//  GCM_LEN_LIMIT_EN undefined:
//    - lim_err_o is tied 0 and no compare logic is built.
//    - Counters wrap modulo 2**LEN_W.
// TESTING
//  1. 2 AAD x16B, 1 text x16B, fin, rdy=1
//     -> len_blk_o = {64'd256, 64'd128}; len_vld_o for 1 cycle; busy_o drops.
//  2. AAD 16B then 5B, text 16B then 1B, fin with rdy=0 for 3 cycles
//     -> {64'd168, 64'd136}, held stable while rdy=0.
//  3. Text 16B then AAD 16B
//     -> seq_err_o=1, len_a=0; later AAD 4B after partial also dropped.
//  4. fin_i with no beats -> len block 0. Text 8B with fin_i in the same cycle
//     -> {0, 64}.
//  5. rst_n low mid-message in TXT -> outputs 0 immediately. clr_i in OUT
//     -> IDLE, len_vld_o=0 next cycle.
//  6. LIMIT_EN, C_MAX_BITS=256: 2x16B then 1B text
//     -> len_c=256, lim_err_o=1. Without the macro, LEN_W=8: 2x16B -> len_c=0 (wrap).

Source files
------------

// File: rtl/gcm_len_tracker.sv
// GCM len(A)||len(C) tracker: counts AAD/text bit lengths and hands the length block to GHASH.
// Optional length-limit checking is built when GCM_LEN_LIMIT_EN is defined.
module gcm_len_tracker #(
    parameter int unsigned LEN_W = 64
`ifdef GCM_LEN_LIMIT_EN
    ,
    parameter logic [63:0] A_MAX_BITS = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter logic [63:0] C_MAX_BITS = 64'd549755813632
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               aad_vld_i,
    input  logic               txt_vld_i,
    input  logic [4:0]         nbytes_i,
    input  logic               fin_i,
    output logic               len_vld_o,
    input  logic               len_rdy_i,
    output logic [2*LEN_W-1:0] len_blk_o,
    output logic               busy_o,
    output logic               seq_err_o,
    output logic               lim_err_o
);

    typedef enum logic [1:0] {StIdle, StAad, StTxt, StOut} state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_a_q, len_a_d, len_c_q, len_c_d;
    logic               a_done_q, a_done_d, c_done_q, c_done_d;
    logic               seq_q, seq_d;

    logic               nz, any_beat, fmt_ok, beat_a, beat_c, partial;
    logic [LEN_W-1:0]   add_bits, sum_a, sum_c;

    assign nz       = (nbytes_i != 5'd0);
    assign any_beat = (aad_vld_i || txt_vld_i) && nz;
    assign fmt_ok   = (nbytes_i <= 5'd16) && !(aad_vld_i && txt_vld_i);
    assign beat_a   = aad_vld_i && any_beat && fmt_ok;
    assign beat_c   = txt_vld_i && any_beat && fmt_ok;
    assign partial  = (nbytes_i < 5'd16);
    assign add_bits = LEN_W'({nbytes_i, 3'b000});
    assign sum_a    = len_a_q + add_bits;
    assign sum_c    = len_c_q + add_bits;

`ifdef GCM_LEN_LIMIT_EN
    logic        lim_q, lim_d;
    logic [64:0] ext_a, ext_c;
    logic        ovf_a, ovf_c;

    // Compare in 65 bits so a full-width LEN_W sum cannot hide an overflow.
    assign ext_a = 65'(len_a_q) + 65'({nbytes_i, 3'b000});
    assign ext_c = 65'(len_c_q) + 65'({nbytes_i, 3'b000});
    assign ovf_a = ext_a > {1'b0, A_MAX_BITS};
    assign ovf_c = ext_c > {1'b0, C_MAX_BITS};
`endif

    always_comb begin
        state_d  = state_q;
        len_a_d  = len_a_q;
        len_c_d  = len_c_q;
        a_done_d = a_done_q;
        c_done_d = c_done_q;
        seq_d    = seq_q;
`ifdef GCM_LEN_LIMIT_EN
        lim_d    = lim_q;
`endif
        if (clr_i) begin
            state_d  = StIdle;
            len_a_d  = '0;
            len_c_d  = '0;
            a_done_d = 1'b0;
            c_done_d = 1'b0;
            seq_d    = 1'b0;
`ifdef GCM_LEN_LIMIT_EN
            lim_d    = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StOut: begin
                    if (any_beat || fin_i) seq_d = 1'b1;
                    if (len_rdy_i) begin
                        state_d  = StIdle;
                        len_a_d  = '0;
                        len_c_d  = '0;
                        a_done_d = 1'b0;
                        c_done_d = 1'b0;
                    end
                end
                StIdle, StAad, StTxt: begin
                    if (any_beat && !fmt_ok) seq_d = 1'b1;
                    if (beat_a) begin
                        if (state_q == StTxt || a_done_q) begin
                            seq_d = 1'b1;
                        end else begin
                            state_d = StAad;
                            if (partial) a_done_d = 1'b1;
`ifdef GCM_LEN_LIMIT_EN
                            if (ovf_a) lim_d = 1'b1;
                            else       len_a_d = sum_a;
`else
                            len_a_d = sum_a;
`endif
                        end
                    end
                    if (beat_c) begin
                        if (c_done_q) begin
                            seq_d = 1'b1;
                        end else begin
                            state_d = StTxt;
                            if (partial) c_done_d = 1'b1;
`ifdef GCM_LEN_LIMIT_EN
                            if (ovf_c) lim_d = 1'b1;
                            else       len_c_d = sum_c;
`else
                            len_c_d = sum_c;
`endif
                        end
                    end
                    // A same-cycle beat has already been folded in above.
                    if (fin_i) state_d = StOut;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            len_a_q  <= '0;
            len_c_q  <= '0;
            a_done_q <= 1'b0;
            c_done_q <= 1'b0;
            seq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_a_q  <= len_a_d;
            len_c_q  <= len_c_d;
            a_done_q <= a_done_d;
            c_done_q <= c_done_d;
            seq_q    <= seq_d;
        end
    end

`ifdef GCM_LEN_LIMIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lim_q <= 1'b0;
        else        lim_q <= lim_d;
    end
    assign lim_err_o = lim_q;
`else
    assign lim_err_o = 1'b0;
`endif

    assign len_vld_o = (state_q == StOut);
    assign busy_o    = (state_q != StIdle);
    assign len_blk_o = {len_a_q, len_c_q};
    assign seq_err_o = seq_q;

endmodule

// File: tb/tb_gcm_len_tracker.sv
// Directed self-checking bench for gcm_len_tracker (64-bit instance plus an 8-bit wrap instance).
module tb_gcm_len_tracker;

    logic         clk = 1'b0;
    logic         rst_n, clr, aad_vld, txt_vld, fin, len_rdy;
    logic [4:0]   nbytes;
    logic         len_vld, busy, seq_err, lim_err;
    logic [127:0] len_blk;
    logic         len_vld8, busy8, seq_err8, lim_err8;
    logic [15:0]  len_blk8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gcm_len_tracker #(
`ifdef GCM_LEN_LIMIT_EN
        .C_MAX_BITS(64'd256),
`endif
        .LEN_W(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .aad_vld_i(aad_vld), .txt_vld_i(txt_vld),
        .nbytes_i(nbytes), .fin_i(fin), .len_vld_o(len_vld), .len_rdy_i(len_rdy),
        .len_blk_o(len_blk), .busy_o(busy), .seq_err_o(seq_err), .lim_err_o(lim_err)
    );

    gcm_len_tracker #(
        .LEN_W(8)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .aad_vld_i(aad_vld), .txt_vld_i(txt_vld),
        .nbytes_i(nbytes), .fin_i(fin), .len_vld_o(len_vld8), .len_rdy_i(len_rdy),
        .len_blk_o(len_blk8), .busy_o(busy8), .seq_err_o(seq_err8), .lim_err_o(lim_err8)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic a, input logic t, input logic [4:0] nb, input logic f);
        aad_vld = a;
        txt_vld = t;
        nbytes  = nb;
        fin     = f;
        tick();
        aad_vld = 1'b0;
        txt_vld = 1'b0;
        nbytes  = 5'd0;
        fin     = 1'b0;
    endtask

    task automatic accept();
        len_rdy = 1'b1;
        tick();
        len_rdy = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; aad_vld = 1'b0; txt_vld = 1'b0;
        fin = 1'b0; len_rdy = 1'b0; nbytes = 5'd0;
        tick(); tick();
        check("rst_vld", len_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_blk", len_blk, 0);
        check("rst_seq", seq_err, 0);
        check("rst_lim", lim_err, 0);
        rst_n = 1'b1;
        tick();

        // 1: two AAD blocks, one text block, rdy held high
        len_rdy = 1'b1;
        beat(1, 0, 16, 0);
        check("t1_busy", busy, 1);
        beat(1, 0, 16, 0);
        beat(0, 1, 16, 0);
        beat(0, 0, 0, 1);
        check("t1_vld", len_vld, 1);
        check("t1_blk", len_blk, {64'd256, 64'd128});
        check("t1_wrap8", len_blk8, {8'd0, 8'd128});
        tick();
        check("t1_vld_drop", len_vld, 0);
        check("t1_busy_drop", busy, 0);
        check("t1_blk_zero", len_blk, 0);
        len_rdy = 1'b0;

        // 2: partial final blocks, consumer stalls 3 cycles
        beat(1, 0, 16, 0);
        beat(1, 0, 5, 0);
        beat(0, 1, 16, 0);
        beat(0, 1, 1, 0);
        beat(0, 0, 0, 1);
        check("t2_blk", len_blk, {64'd168, 64'd136});
        tick(); tick(); tick();
        check("t2_hold_vld", len_vld, 1);
        check("t2_hold_blk", len_blk, {64'd168, 64'd136});
        check("t2_seq", seq_err, 0);
        accept();
        check("t2_idle", busy, 0);

        // 3: AAD after text is dropped
        beat(0, 1, 16, 0);
        beat(1, 0, 16, 0);
        check("t3_seq", seq_err, 1);
        check("t3_blk", len_blk, {64'd0, 64'd128});
        beat(0, 0, 0, 1);
        accept();
        do_clr();
        check("t3_clr_seq", seq_err, 0);
        beat(1, 0, 4, 0);
        beat(1, 0, 4, 0);
        check("t3_partial_seq", seq_err, 1);
        check("t3_partial_blk", len_blk, {64'd32, 64'd0});
        beat(0, 0, 0, 1);
        accept();
        do_clr();

        // Illegal beat formats are dropped
        beat(1, 1, 16, 0);
        check("both_seq", seq_err, 1);
        check("both_busy", busy, 0);
        check("both_blk", len_blk, 0);
        do_clr();
        beat(0, 1, 17, 0);
        check("nb17_seq", seq_err, 1);
        check("nb17_blk", len_blk, 0);
        do_clr();

        // 4: empty message and beat coincident with fin
        beat(0, 0, 0, 1);
        check("t4_empty_vld", len_vld, 1);
        check("t4_empty_blk", len_blk, 0);
        accept();
        beat(0, 1, 8, 1);
        check("t4_fin_beat", len_blk, {64'd0, 64'd64});
        beat(1, 0, 16, 0);
        check("t4_out_seq", seq_err, 1);
        check("t4_out_hold", len_blk, {64'd0, 64'd64});
        accept();
        do_clr();

        // 5: async reset mid-message, then clear in OUT
        beat(0, 1, 16, 0);
        check("t5_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_blk", len_blk, 0);
        tick();
        rst_n = 1'b1;
        tick();
        beat(1, 0, 16, 1);
        check("t5_out_blk", len_blk, {64'd128, 64'd0});
        do_clr();
        check("t5_clr_vld", len_vld, 0);
        check("t5_clr_busy", busy, 0);
        check("t5_clr_blk", len_blk, 0);

`ifdef GCM_LEN_LIMIT_EN
        // 6: text limit of 256 bits
        beat(0, 1, 16, 0);
        beat(0, 1, 16, 0);
        beat(0, 1, 1, 0);
        check("t6_lim", lim_err, 1);
        check("t6_blk", len_blk, {64'd0, 64'd256});
        check("t6_busy", busy, 1);
        beat(0, 0, 0, 1);
        accept();
`else
        beat(0, 1, 16, 0);
        beat(0, 1, 16, 0);
        check("t6_wrap8", len_blk8, {8'd0, 8'd0});
        check("t6_nolim", lim_err, 0);
        beat(0, 0, 0, 1);
        accept();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
